// File: rtl/seven_seg_mux_pkg.sv
// seven_seg_mux_pkg: segment bit indices, hex-to-segment table and width helper for the display driver
package seven_seg_mux_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_DP = 7;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seven_seg_mux_if.sv
// seven_seg_mux_if: register-side inputs and display-pin outputs of the scan driver
interface seven_seg_mux_if #(parameter int NUM_DIGITS = 8);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0] dp;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic blank_lz;
  logic [3:0] brightness;
  logic [NUM_DIGITS-1:0] seg_en;
  logic [7:0] seg_data;
  logic frame_tick;
  modport master (output data, dp, blink_mask, blank_lz, brightness, input seg_en, seg_data, frame_tick);
  modport slave (input data, dp, blink_mask, blank_lz, brightness, output seg_en, seg_data, frame_tick);
endinterface

// File: rtl/seven_seg_mux_seg_hex_decode.sv
// seg_hex_decode: nibble to active-high g..a segment pattern
module seg_hex_decode
  import seven_seg_mux_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed hex display scanner with blanking, blink and PWM brightness
module seven_seg_mux
  import seven_seg_mux_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int REFRESH_DIV = 16384,
  parameter int BLINK_FRAMES = 64,
  parameter int EN_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input logic clk,
  input logic resetn,
  seven_seg_mux_if.slave bus
);
  localparam int CW = cnt_w(REFRESH_DIV);
  localparam int IW = cnt_w(NUM_DIGITS);
  localparam int FW = cnt_w(BLINK_FRAMES);
  localparam logic [NUM_DIGITS-1:0] EN_INV = {NUM_DIGITS{EN_ACTIVE_LOW != 0}};
  localparam logic [7:0] SEG_INV = {8{SEG_ACTIVE_LOW != 0}};
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic phase, phase_n;
  logic [4*NUM_DIGITS-1:0] sh_data, sh_data_n;
  logic [NUM_DIGITS-1:0] sh_dp, sh_dp_n, sh_blink, sh_blink_n;
  logic sh_lz, sh_lz_n;
  logic [3:0] sh_bri, sh_bri_n;
  logic tick, fstart, fwrap, lit, zb, bb, acc;
  logic [3:0] nib;
  logic [6:0] seg7;
  logic [NUM_DIGITS-1:0] za, en_n, en_q;
  logic [7:0] seg_n, seg_q;
  logic ft_q;
  // next state of counters, blink phase and frame-start shadow capture
  always_comb begin
    tick = cnt == CW'(REFRESH_DIV - 1);
    fstart = tick && idx == IW'(NUM_DIGITS - 1);
    fwrap = fcnt == FW'(BLINK_FRAMES - 1);
    cnt_n = cnt + 1'b1;
    idx_n = !tick ? idx : fstart ? '0 : idx + 1'b1;
    fcnt_n = !fstart ? fcnt : fwrap ? '0 : fcnt + 1'b1;
    phase_n = phase ^ (fstart && fwrap);
    sh_data_n = fstart ? bus.data : sh_data;
    sh_dp_n = fstart ? bus.dp : sh_dp;
    sh_blink_n = fstart ? bus.blink_mask : sh_blink;
    sh_lz_n = fstart ? bus.blank_lz : sh_lz;
    sh_bri_n = fstart ? bus.brightness : sh_bri;
  end
  // za[i] is set when nibbles i..N-1 are all zero
  always_comb begin
    za = '0;
    acc = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc = acc & (sh_data_n[4*i +: 4] == 4'h0);
      za[i] = acc;
    end
  end
  seg_hex_decode u_dec (.nib(nib), .seg(seg7));
  // active-high pin values for the slot that starts on the coming edge
  always_comb begin
    nib = sh_data_n[{idx_n, 2'b00} +: 4];
    lit = cnt_n[CW-1 -: 4] <= sh_bri_n;
    zb = sh_lz_n && idx_n != '0 && za[idx_n];
    bb = phase_n && sh_blink_n[idx_n];
    en_n = lit ? NUM_DIGITS'(1) << idx_n : '0;
    seg_n = '0;
    seg_n[SEG_DP] = lit && !bb && sh_dp_n[idx_n];
    seg_n[SEG_G:SEG_A] = (lit && !bb && !zb) ? seg7 : 7'h0;
  end
  // scan state and shadow registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      idx <= '0;
      fcnt <= '0;
      phase <= 1'b0;
      sh_data <= '0;
      sh_dp <= '0;
      sh_blink <= '0;
      sh_lz <= 1'b0;
      sh_bri <= '0;
    end else begin
      cnt <= cnt_n;
      idx <= idx_n;
      fcnt <= fcnt_n;
      phase <= phase_n;
      sh_data <= sh_data_n;
      sh_dp <= sh_dp_n;
      sh_blink <= sh_blink_n;
      sh_lz <= sh_lz_n;
      sh_bri <= sh_bri_n;
    end
  end
  // output registers, polarity applied only here
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q <= NUM_DIGITS'(1) ^ EN_INV;
      seg_q <= SEG_INV;
      ft_q <= 1'b0;
    end else begin
      en_q <= en_n ^ EN_INV;
      seg_q <= seg_n ^ SEG_INV;
      ft_q <= fstart;
    end
  end
  assign bus.seg_en = en_q;
  assign bus.seg_data = seg_q;
  assign bus.frame_tick = ft_q;
endmodule
